// File: rtl/port_input_buffer_if.sv
// Flit-side bundle between an upstream link, the port input buffer and the round-robin arbiter.
// The master modport belongs to the upstream/arbiter side; the slave modport belongs to the buffer.
interface port_input_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  valid_in;
  logic                  ready_out;
  logic                  grant;
  logic                  req;
  logic [2:0]            flit_id;
  logic [11:0]           length;
  logic [DATA_WIDTH-1:0] flit_out;
  logic                  flit_valid_out;

  modport master (
    output flit_in, valid_in, grant,
    input  ready_out, req, flit_id, length, flit_out, flit_valid_out
  );

  modport slave (
    input  flit_in, valid_in, grant,
    output ready_out, req, flit_id, length, flit_out, flit_valid_out
  );
endinterface

// File: rtl/port_input_buffer.sv
// Per-port flit FIFO with head decode and IDLE/PKT packet tracker; zero-cycle head latency, ready_out = !full.
// Define INBUF_DROP_CNT_EN to add the saturating 8-bit drop_cnt output.
module port_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  port_input_buffer_if.slave  bus
`ifdef INBUF_DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  state_e                state_q, state_d;

  logic                  empty, full, push, pop, drop, req_c;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            head_id;
  logic                  head_hdr, head_tail, head_legal;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL_CNT);
  assign push       = bus.valid_in && !full;
  assign head       = mem_q[rd_ptr_q];
  assign head_id    = head[DATA_WIDTH-1 -: 3];
  assign head_hdr   = (head_id == 3'b001);
  assign head_tail  = (head_id == 3'b100);
  assign head_legal = head_hdr || head_tail || (head_id == 3'b010);

  // Drops never depend on grant: a malformed head is discarded one per cycle on its own.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    drop    = 1'b0;
    req_c   = 1'b0;
    if (!empty) begin
      if (state_q == ST_IDLE) begin
        drop  = !head_hdr;
        req_c = head_hdr;
        if (head_hdr && bus.grant) begin
          pop     = 1'b1;
          state_d = ST_PKT;
        end
      end else begin
        drop  = !head_legal;
        req_c = head_legal;
        if (head_legal && bus.grant) begin
          pop = 1'b1;
          if (head_tail) begin
            state_d = ST_IDLE;
          end
        end
      end
      if (drop) begin
        pop = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // Storage is left unreset; empty/full gate every use of its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.flit_in;
    end
  end

  assign bus.ready_out      = !full;
  assign bus.req            = req_c;
  assign bus.flit_id        = empty ? 3'b000 : head_id;
  assign bus.length         = (!empty && head_hdr) ? head[11:0] : 12'd0;
  assign bus.flit_out       = head;
  assign bus.flit_valid_out = pop && !drop;

`ifdef INBUF_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/port_input_buffer.md
# port_input_buffer

Per-port flit input buffer for the 5-port router: one instance each for L, N, E, W, S. It stores incoming flits in a small FIFO and decodes the head flit. It drives the request, flit_id and length inputs of the round-robin arbiter, and pops flits while that arbiter grants the port. A two-state packet tracker holds the request asserted from header to tail and drops malformed flits.

## Interface
- DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-3] carry flit_id; header flits carry packet length in bits [11:0]
- DEPTH, 4, FIFO entries; power of two, minimum 2
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset; the polarity and synchronicity are fixed
- flit_in  input  DATA_WIDTH  incoming flit
- valid_in  input  1  flit_in valid
- ready_out  output  1  buffer can accept; equals !full
- grant  input  1  this port's bit of the arbiter's one-hot state
- req  output  1  request to arbiter
- flit_id  output  3  id of head flit; 3'b000 when empty
- length  output  12  head flit [11:0] when head is a header, else 12'd0
- flit_out  output  DATA_WIDTH  head flit (mem[rd_ptr]), combinational
- flit_valid_out  output  1  flit_out is popped this cycle
- drop_cnt  output  8  dropped-flit counter; present only with INBUF_DROP_CNT_EN

## Operation
- Flit ids: 3'b001 header, 3'b010 body, 3'b100 tail. Any other id is illegal.
- **Push:** occurs when valid_in && ready_out. The flit is written at wr_ptr, and the pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 gives full/empty.
- **States:** IDLE and PKT.
- **IDLE:**
  - req = head valid && id==001.
  - Pop on grant && header at head; go to PKT.
  - A head flit with any id other than 001 is dropped: it is popped without grant, one per cycle, and flit_valid_out stays 0.
- **PKT:**
  - req = !empty && head id legal.
  - Pop on grant && !empty && head id legal.
  - Popping a tail flit returns the state to IDLE.
  - Popping a header flit (missing tail) starts a new packet; the state stays PKT.
  - Illegal ids are dropped as in IDLE.
- flit_valid_out = pop && !drop.
- grant with an empty FIFO, or in IDLE with a non-header at head, does not cause a forwarding pop.
- Push and pop in the same cycle leave occupancy unchanged. A push into a full FIFO cannot occur, because ready_out is 0.
- While the arbiter holds the grant for a packet, its timer latches length when flit_id==001 is presented.

## Timing
- **Reset (rst low, async):**
  - Pointers and occupancy are 0 and the state is IDLE.
  - Outputs: req=0, flit_id=000, length=0, flit_valid_out=0, ready_out=1, drop_cnt=0.
  - FIFO contents are don't-care.
- Reset asserted mid-packet discards all buffered flits.
- A flit pushed at edge N is at the head, and req is valid, after edge N if the FIFO was empty: zero-cycle head latency, with outputs combinational from registered state.
- A pop at edge N exposes the next flit immediately after N.
- Sustained throughput is one flit per cycle in and one out.
- req, flit_id, length and flit_out are combinational from registers only. They have no path from grant or valid_in, so there are no loops through the arbiter.

## Configuration
- **INBUF_DROP_CNT_EN defined:**
  - drop_cnt port exists.
  - It is an 8-bit counter that increments on every dropped flit, saturates at 255 and clears on reset.
- **INBUF_DROP_CNT_EN undefined:**
  - Port and counter are absent.
  - Drop behaviour is otherwise identical.

## Test plan
- **Reset:** pulse rst low mid-cycle -> outputs immediately req=0, flit_id=000, length=0, ready_out=1; after release, FIFO empty.
- **Single packet:** push header (len 12'h00A), body, tail; hold grant=1 -> req=1 from the cycle after the header push, length=10 while the header is at head, three pops with flit_valid_out=1, then IDLE with req=0.
- **Full FIFO:**
  - Setup: DEPTH=4, grant=0; push 5 flits with valid_in held.
  - Required: ready_out=0 after the 4th push; the 5th flit is not accepted until one pop; the accepted sequence is then intact.
- **Illegal ids:** push 3'b111 then a header in IDLE -> illegal flit dropped in 1 cycle without grant, then header with req=1; drop_cnt=1 with INBUF_DROP_CNT_EN.
- **Missing tail:** header, body, header, tail under grant -> state stays PKT across the second header, ends IDLE; 4 flits forwarded.
- **Simultaneous push/pop and wrap:** 20 back-to-back flits with grant=1 -> occupancy constant, order preserved across pointer wrap, and one flit out per cycle.
